i2c_oled_target: RTL

I2C write-only target (responder) that acts as the far end of the OLED I2C link. It models the SSD1306 framing the OLED controller expects. It oversamples SCL/SDA on the system clock, matches its 7-bit address, ACKs by pulling SDA low, and decodes SSD1306 control bytes. Each received payload byte is emitted as a one-cycle strobe tagged as command or display data. It sits on the same `scl`/`sda` wires as the I2C master, for loopback verification and for on-chip display-shadow capture.

---
 rtl/i2c_target_pkg.sv | 25 ++
 rtl/i2c_line_sync.sv | 57 +++++
 rtl/i2c_oled_target.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the SSD1306-style I2C write target.
package i2c_target_pkg;

  // Protocol states. The ACK states cover the whole 9th SCL clock of a byte.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CTRL     = 3'd3,
    ST_CTRL_ACK = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  // SSD1306 control byte: Co selects single-byte (1) or streaming (0),
  // D/C selects GDDRAM data (1) or command (0).
  localparam int CO_BIT = 7;
  localparam int DC_BIT = 6;

  localparam logic [6:0] DEFAULT_ADDR = 7'h3C;
  localparam logic [3:0] LAST_BIT     = 4'd7;
  localparam logic [3:0] BYTE_BITS    = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with registered edge and START/STOP condition flags.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_h_q, sda_h_q;
  logic scl_now, sda_now;
  logic scl_rise_q, scl_fall_q, sda_s_q, start_q, stop_q;

  assign scl_now = scl_sync_q[SYNC_STAGES-1];
  assign sda_now = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chain, history flop and flag registers. Lines reset to the
  // idle-high level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_s_q    <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_h_q    <= scl_now;
      sda_h_q    <= sda_now;
      scl_rise_q <= scl_now & ~scl_h_q;
      scl_fall_q <= ~scl_now & scl_h_q;
      sda_s_q    <= sda_now;
      // SDA moving while SCL is steadily high is a bus condition, not data.
      start_q    <= scl_now & scl_h_q & sda_h_q & ~sda_now;
      stop_q     <= scl_now & scl_h_q & ~sda_h_q & sda_now;
    end
  end

  assign scl_rise = scl_rise_q;
  assign scl_fall = scl_fall_q;
  assign sda_s    = sda_s_q;
  assign start_c  = start_q;
  assign stop_c   = stop_q;

endmodule

// File: rtl/i2c_oled_target.sv
// Write-only I2C target decoding SSD1306 control/data framing.
module i2c_oled_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       addr_nack
);

  logic scl_rise, scl_fall, sda_s, start_c, stop_c;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_c  (start_c),
    .stop_c   (stop_c)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       co_q, co_d, dc_q, dc_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_dc_q, rx_dc_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic       nack_q, nack_d;
  logic [7:0] byte_in;

  // Byte as it will stand once the current SDA sample is shifted in.
  assign byte_in = {sh_q[6:0], sda_s};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      co_q       <= 1'b0;
      dc_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_dc_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      co_q       <= co_d;
      dc_q       <= dc_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_dc_q    <= rx_dc_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end

  // Next-state logic: bus conditions first, then bit shifting / ACK slot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    co_d       = co_q;
    dc_d       = dc_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_dc_d    = rx_dc_q;
    start_d    = start_c;
    stop_d     = stop_c;
    nack_d     = 1'b0;

    if (stop_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      // Any partial byte is dropped here; it never reaches rx_valid.
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: oe_d = 1'b0;

        ST_ADDR, ST_CTRL, ST_DATA: begin
          if (scl_rise) begin
            sh_d = byte_in;
            if (cnt_q == LAST_BIT) begin
              cnt_d = BYTE_BITS;
              case (state_q)
                ST_ADDR: begin
                  if (byte_in[7:1] == ADDR && !byte_in[0]) begin
                    state_d = ST_ADDR_ACK;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IGNORE;
                    nack_d  = 1'b1;
                  end
                end
                ST_CTRL: begin
                  co_d    = byte_in[CO_BIT];
                  dc_d    = byte_in[DC_BIT];
                  state_d = ST_CTRL_ACK;
                end
                default: begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = byte_in;
                  rx_dc_d    = dc_q;
                  state_d    = ST_DATA_ACK;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end

        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          // First fall opens the ACK slot, the next one closes it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              case (state_q)
                ST_ADDR_ACK: state_d = ST_CTRL;
                ST_CTRL_ACK: state_d = ST_DATA;
                default:     state_d = co_q ? ST_CTRL : ST_DATA;
              endcase
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Open-drain: only ever pull low.
  assign sda = oe_q ? 1'b0 : 1'bz;

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_dc     = rx_dc_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign busy      = busy_q;
  assign addr_nack = nack_q;

endmodule
